trap_commit: RTL and testbench

- Commit stage directly downstream of the misc/ALU execute units. Consumes one exec_result per handshake and commits it.
- On a normal result: performs the register-file write and any branch redirect.
- On an exception: saves M-mode trap CSRs and redirects to mtvec. On MRET: restores mstatus and redirects to mepc.
- Owns the machine trap CSRs (mstatus.MIE/MPIE, mepc, mcause, mtval, mtvec) and exposes a CSR read/write port.

---
 rtl/trap_commit_pkg.sv | 32 +++
 rtl/trap_commit_if.sv | 54 +++++
 rtl/trap_commit_csrs.sv | 129 ++++++++++++
 rtl/trap_commit.sv | 158 +++++++++++++++
 tb/tb_trap_commit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_commit_pkg.sv
// trap_commit_pkg
// Shared types and constants for the commit stage and its machine trap CSRs.
// Contents:
//   trap_state_t : commit FSM states (IDLE, TRAP_SAVE, TRAP_JUMP)
//   CSR_*        : machine-mode CSR addresses served by the CSR port
//   MSTATUS_*    : bit positions of the implemented mstatus fields
//   ex_type_t    : 4-bit exception codes carried on res_ex
package trap_commit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAP_SAVE = 2'd1,
    TRAP_JUMP = 2'd2
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [3:0] {
    EX_INSTR_MISALIGNED = 4'd0,
    EX_ILLEGAL_INSTR    = 4'd2,
    EX_BREAKPOINT       = 4'd3,
    EX_M_ECALL          = 4'd11
  } ex_type_t;

endpackage

// File: rtl/trap_commit_if.sv
// trap_commit_if
// Bundles everything the commit stage exchanges with its neighbours:
//   res_*      : exec_result handshake from the execute units (res_ready back)
//   rf_*       : register-file write port driven by commit
//   redirect_* : fetch redirect / upstream flush driven by commit
//   csr_*      : CSR read/write port used by the CSR instruction unit
// Modports:
//   master : the upstream side (execute units, CSR unit, register file, fetch)
//   slave  : the commit stage itself
interface trap_commit_if #(
  parameter int XLEN = 32
);

  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_pc;
  logic [4:0]      res_rd_idx;
  logic [XLEN-1:0] res_rd_val;
  logic            res_br_valid;
  logic [XLEN-1:0] res_br_target;
  logic            res_ex_valid;
  logic [3:0]      res_ex;
  logic [XLEN-1:0] res_ex_tval;
  logic            res_ret_valid;

  logic            rf_we;
  logic [4:0]      rf_idx;
  logic [XLEN-1:0] rf_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output res_valid, res_pc, res_rd_idx, res_rd_val, res_br_valid,
           res_br_target, res_ex_valid, res_ex, res_ex_tval, res_ret_valid,
           csr_we, csr_addr, csr_wdata,
    input  res_ready, rf_we, rf_idx, rf_data, redirect_valid, redirect_pc,
           csr_rdata
  );

  modport slave (
    input  res_valid, res_pc, res_rd_idx, res_rd_val, res_br_valid,
           res_br_target, res_ex_valid, res_ex, res_ex_tval, res_ret_valid,
           csr_we, csr_addr, csr_wdata,
    output res_ready, rf_we, rf_idx, rf_data, redirect_valid, redirect_pc,
           csr_rdata
  );

endinterface

// File: rtl/trap_commit_csrs.sv
// m_trap_csrs
// Storage for the machine trap CSRs (mstatus.MIE/MPIE, mtvec, mepc, mcause,
// mtval) with the read mux and the arbitration between the CSR port, the
// trap-save update and the MRET mstatus update.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   csr_we_i        : CSR write strobe, already qualified by the commit FSM
//   csr_addr_i      : CSR address for both read and write
//   csr_wdata_i     : CSR write data
//   csr_rdata_o     : combinational read of csr_addr_i
//   trap_save_i     : capture save_* into mepc/mcause/mtval and stack MIE
//   save_pc_i       : pc of the trapping instruction
//   save_cause_i    : zero-extended cause
//   save_tval_i     : trap value
//   mret_i          : MRET committing this cycle
//   mtvec_o, mepc_o : current trap vector base and exception pc
module m_trap_csrs
  import trap_commit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic            trap_save_i,
  input  logic [XLEN-1:0] save_pc_i,
  input  logic [XLEN-1:0] save_cause_i,
  input  logic [XLEN-1:0] save_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] LOW2_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  // Next-state arbitration. The CSR port is applied first, then the trap
  // save, then MRET, so that a later source overrides an earlier one when
  // they touch the same field. The FSM never raises csr_we_i and
  // trap_save_i together, so only the MRET-over-mstatus-write case really
  // collides. mtvec and mepc keep bits [1:0] cleared in storage so that the
  // read mux and the redirect path can use them directly.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;

    if (csr_we_i) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata_i[MSTATUS_MIE_BIT];
          mpie_d = csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:  mtvec_d  = csr_wdata_i & LOW2_MASK;
        CSR_MEPC:   mepc_d   = csr_wdata_i & LOW2_MASK;
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        CSR_MTVAL:  mtval_d  = csr_wdata_i;
        default: ;
      endcase
    end

    if (trap_save_i) begin
      mepc_d   = save_pc_i & LOW2_MASK;
      mcause_d = save_cause_i;
      mtval_d  = save_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end

    if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // CSR registers with synchronous reset; mtvec comes up at the configured
  // vector, everything else at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC & LOW2_MASK;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

  // Combinational read mux. mstatus only exposes MIE and MPIE; unmapped
  // addresses read as zero.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE_BIT]  = mie_q;
        csr_rdata_o[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_q;
      default: ;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_commit.sv
// trap_commit
// Commit stage behind the misc/ALU execute units. Accepts one exec_result
// per handshake in IDLE and either commits it (register write plus optional
// branch redirect), takes a trap (save CSRs, then redirect to mtvec) or
// executes MRET (restore mstatus, redirect to mepc).
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : trap_commit_if.slave carrying the exec_result handshake, the
//         register-file write port, the fetch redirect and the CSR port
module trap_commit
  import trap_commit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  trap_commit_if.slave bus
);

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_idx_q, rf_idx_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic            accept;
  logic            misaligned;
  logic            take_trap;
  logic            take_mret;
  logic            csr_we_ok;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  // Accept classification. A taken control transfer to a non-word-aligned
  // target is treated exactly like a raised exception, so it also outranks
  // MRET. CSR writes are only honoured while the FSM is idle.
  assign accept     = bus.res_valid && (state_q == IDLE);
  assign misaligned = bus.res_br_valid && (bus.res_br_target[1:0] != 2'b00);
  assign take_trap  = accept && (bus.res_ex_valid || misaligned);
  assign take_mret  = accept && !take_trap && bus.res_ret_valid;
  assign csr_we_ok  = bus.csr_we && (state_q == IDLE);

  m_trap_csrs #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csrs (
    .clk          (clk),
    .rst          (rst),
    .csr_we_i     (csr_we_ok),
    .csr_addr_i   (bus.csr_addr),
    .csr_wdata_i  (bus.csr_wdata),
    .csr_rdata_o  (bus.csr_rdata),
    .trap_save_i  (state_q == TRAP_SAVE),
    .save_pc_i    (pc_q),
    .save_cause_i (cause_q),
    .save_tval_i  (tval_q),
    .mret_i       (take_mret),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc)
  );

  // FSM next state and commit outputs. All outputs are registered, so
  // whatever is decided here shows up in the following cycle: one cycle
  // after accept for normal results and MRET, and for traps the redirect is
  // scheduled while in TRAP_SAVE so it is visible during TRAP_JUMP, two
  // cycles after accept. The pulse outputs default to zero every cycle.
  // MRET reads mepc before any same-cycle CSR write has landed.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    rf_we_d       = 1'b0;
    rf_idx_d      = rf_idx_q;
    rf_data_d     = rf_data_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;

    case (state_q)
      IDLE: begin
        if (take_trap) begin
          state_d = TRAP_SAVE;
          pc_d    = bus.res_pc;
          if (bus.res_ex_valid) begin
            cause_d = {{(XLEN-4){1'b0}}, bus.res_ex};
            tval_d  = bus.res_ex_tval;
          end else begin
            cause_d = {{(XLEN-4){1'b0}}, EX_INSTR_MISALIGNED};
            tval_d  = bus.res_br_target;
          end
        end else if (take_mret) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = mepc;
        end else if (accept) begin
          rf_we_d   = (bus.res_rd_idx != 5'd0);
          rf_idx_d  = bus.res_rd_idx;
          rf_data_d = bus.res_rd_val;
          if (bus.res_br_valid) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = bus.res_br_target;
          end
        end
      end
      TRAP_SAVE: begin
        state_d       = TRAP_JUMP;
        redir_valid_d = 1'b1;
        redir_pc_d    = mtvec;
      end
      TRAP_JUMP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears any in-flight trap sequence
  // together with the pending outputs, so an abandoned trap never redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      rf_we_q       <= 1'b0;
      rf_idx_q      <= '0;
      rf_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      rf_we_q       <= rf_we_d;
      rf_idx_q      <= rf_idx_d;
      rf_data_q     <= rf_data_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.res_ready      = (state_q == IDLE);
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_idx         = rf_idx_q;
  assign bus.rf_data        = rf_data_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_trap_commit.sv
// tb_trap_commit
// Directed bench for trap_commit. Stimulus pushes the expected register
// write / redirect pulse (with the cycle it must appear in) onto a
// scoreboard queue; a separate monitor pops and compares whenever the DUT
// raises rf_we or redirect_valid. CSR contents and res_ready are compared
// directly against hand-computed constants.
module tb_trap_commit;
  import trap_commit_pkg::*;

  localparam logic [31:0] RST_VEC = 32'h0000_0100;

  typedef struct {
    bit          rf;
    logic [4:0]  idx;
    logic [31:0] data;
    bit          rd;
    logic [31:0] pc;
    int          at;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sbq[$];

  trap_commit_if #(.XLEN(32)) bus ();

  trap_commit #(
    .XLEN        (32),
    .RESET_MTVEC (RST_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock plus a cycle counter used to timestamp expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit rf, input logic [4:0] idx, input logic [31:0] data,
                         input bit rd, input logic [31:0] pc, input int lat);
    exp_t e;
    e.rf   = rf;
    e.idx  = idx;
    e.data = data;
    e.rd   = rd;
    e.pc   = pc;
    e.at   = cyc + lat;
    sbq.push_back(e);
  endtask

  // Present one exec_result for exactly one clock edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rdIdx,
                               input logic [31:0] rdVal, input bit brValid,
                               input logic [31:0] brTarget, input bit exValid,
                               input logic [3:0] ex, input logic [31:0] exTval,
                               input bit retValid);
    bus.res_valid     = 1'b1;
    bus.res_pc        = pc;
    bus.res_rd_idx    = rdIdx;
    bus.res_rd_val    = rdVal;
    bus.res_br_valid  = brValid;
    bus.res_br_target = brTarget;
    bus.res_ex_valid  = exValid;
    bus.res_ex        = ex;
    bus.res_ex_tval   = exTval;
    bus.res_ret_valid = retValid;
    @(posedge clk);
    #1;
    bus.res_valid     = 1'b0;
    bus.res_br_valid  = 1'b0;
    bus.res_ex_valid  = 1'b0;
    bus.res_ret_valid = 1'b0;
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    @(posedge clk);
    #1;
    bus.csr_we = 1'b0;
  endtask

  task automatic checkCsr(input string name, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_addr = addr;
    #1;
    checkOutput(name, bus.csr_rdata, exp);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: flags expectations whose cycle has passed unseen, and checks
  // every rf_we / redirect_valid pulse against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL missed_pulse: got none expected pulse at cycle %0d (now %0d)", sbq[0].at, cyc);
        void'(sbq.pop_front());
      end
      if (bus.rf_we || bus.redirect_valid) begin
        if (sbq.size() == 0 || sbq[0].at != cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_pulse: got rf_we=%0b redirect_valid=%0b pc=0x%08h at cycle %0d expected none",
                   bus.rf_we, bus.redirect_valid, bus.redirect_pc, cyc);
        end else begin
          e = sbq.pop_front();
          checkOutput("rf_we", {31'd0, bus.rf_we}, {31'd0, e.rf});
          if (e.rf) begin
            checkOutput("rf_idx", {27'd0, bus.rf_idx}, {27'd0, e.idx});
            checkOutput("rf_data", bus.rf_data, e.data);
          end
          checkOutput("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rd});
          if (e.rd) checkOutput("redirect_pc", bus.redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin
    int cnt;
    vectors           = 0;
    miscompares       = 0;
    rst               = 1'b1;
    bus.res_valid     = 1'b0;
    bus.res_pc        = '0;
    bus.res_rd_idx    = '0;
    bus.res_rd_val    = '0;
    bus.res_br_valid  = 1'b0;
    bus.res_br_target = '0;
    bus.res_ex_valid  = 1'b0;
    bus.res_ex        = '0;
    bus.res_ex_tval   = '0;
    bus.res_ret_valid = 1'b0;
    bus.csr_we        = 1'b0;
    bus.csr_addr      = '0;
    bus.csr_wdata     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset res_ready", {31'd0, bus.res_ready}, 32'd1);
    checkOutput("reset rf_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    checkCsr("reset mtvec", CSR_MTVEC, RST_VEC);
    checkCsr("reset mstatus", CSR_MSTATUS, 32'h0);
    checkCsr("reset mepc", CSR_MEPC, 32'h0);
    idleCycles(1);

    pushExp(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0, 1);
    applyStimulus(32'h100, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    applyStimulus(32'h104, 5'd0, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    checkOutput("x0 rf_we", {31'd0, bus.rf_we}, 32'd0);

    pushExp(1'b1, 5'd1, 32'h0000_010C, 1'b1, 32'h0000_1000, 1);
    applyStimulus(32'h108, 5'd1, 32'h0000_010C, 1'b1, 32'h0000_1000, 1'b0, 4'd0, 32'h0, 1'b0);
    pushExp(1'b0, 5'd0, 32'h0, 1'b1, RST_VEC, 2);
    applyStimulus(32'h10C, 5'd2, 32'h0000_0055, 1'b1, 32'h0000_1002, 1'b0, 4'd0, 32'h0, 1'b0);
    csrWrite(CSR_MTVEC, 32'h0000_3000);
    idleCycles(1);
    checkCsr("misaligned mcause", CSR_MCAUSE, 32'h0);
    checkCsr("misaligned mtval", CSR_MTVAL, 32'h0000_1002);
    checkCsr("misaligned mepc", CSR_MEPC, 32'h0000_010C);
    checkCsr("mtvec write ignored in trap", CSR_MTVEC, RST_VEC);
    checkCsr("misaligned mstatus", CSR_MSTATUS, 32'h0);

    csrWrite(CSR_MTVEC, 32'h8000_0003);
    csrWrite(CSR_MSTATUS, 32'h0000_0008);
    checkCsr("mtvec low bits", CSR_MTVEC, 32'h8000_0000);
    checkCsr("mstatus MIE set", CSR_MSTATUS, 32'h0000_0008);
    idleCycles(1);
    pushExp(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0000, 2);
    applyStimulus(32'h200, 5'd7, 32'h0000_0077, 1'b0, 32'h0, 1'b1, EX_M_ECALL, 32'h0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_ready) break;
      cnt++;
    end
    checkOutput("ecall ready low cycles", cnt, 32'd2);
    idleCycles(1);
    checkCsr("ecall mepc", CSR_MEPC, 32'h0000_0200);
    checkCsr("ecall mcause", CSR_MCAUSE, 32'd11);
    checkCsr("ecall mtval", CSR_MTVAL, 32'h0);
    checkCsr("ecall mstatus", CSR_MSTATUS, 32'h0000_0080);

    csrWrite(CSR_MEPC, 32'h0000_0204);
    pushExp(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0204, 1);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = CSR_MEPC;
    bus.csr_wdata = 32'h0000_0300;
    applyStimulus(32'h208, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1);
    bus.csr_we = 1'b0;
    checkCsr("mret mstatus", CSR_MSTATUS, 32'h0000_0088);
    checkCsr("mret csr mepc", CSR_MEPC, 32'h0000_0300);
    idleCycles(1);
    pushExp(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0300, 1);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = CSR_MSTATUS;
    bus.csr_wdata = 32'h0;
    applyStimulus(32'h20C, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1);
    bus.csr_we = 1'b0;
    checkCsr("mret beats csr mstatus", CSR_MSTATUS, 32'h0000_0088);
    idleCycles(1);

    for (int i = 0; i < 4; i++) begin
      pushExp(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1);
      applyStimulus(32'h300 + 32'(4 * i), 5'(10 + i), 32'hA000_0000 + 32'(i),
                    1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    end

    pushExp(1'b1, 5'd20, 32'h0000_1111, 1'b0, 32'h0, 1);
    applyStimulus(32'h3FC, 5'd20, 32'h0000_1111, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    pushExp(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0000, 2);
    applyStimulus(32'h400, 5'd21, 32'h0000_0021, 1'b0, 32'h0, 1'b1, EX_ILLEGAL_INSTR, 32'h0000_0BAD, 1'b0);
    bus.res_valid  = 1'b1;
    bus.res_pc     = 32'h404;
    bus.res_rd_idx = 5'd22;
    bus.res_rd_val = 32'h0000_2222;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_ready) break;
      cnt++;
    end
    pushExp(1'b1, 5'd22, 32'h0000_2222, 1'b0, 32'h0, 1);
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    checkOutput("stream ready low cycles", cnt, 32'd2);
    idleCycles(1);
    checkCsr("illegal mepc", CSR_MEPC, 32'h0000_0400);
    checkCsr("illegal mcause", CSR_MCAUSE, 32'd2);
    checkCsr("illegal mtval", CSR_MTVAL, 32'h0000_0BAD);
    checkCsr("illegal mstatus", CSR_MSTATUS, 32'h0000_0080);

    idleCycles(1);
    applyStimulus(32'h500, 5'd3, 32'h0, 1'b0, 32'h0, 1'b1, EX_BREAKPOINT, 32'h0000_0500, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post-reset res_ready", {31'd0, bus.res_ready}, 32'd1);
    checkOutput("post-reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("post-reset rf_idx", {27'd0, bus.rf_idx}, 32'd0);
    checkOutput("post-reset rf_data", bus.rf_data, 32'h0);
    checkOutput("post-reset redirect_pc", bus.redirect_pc, 32'h0);
    checkCsr("post-reset mtvec", CSR_MTVEC, RST_VEC);
    checkCsr("post-reset mstatus", CSR_MSTATUS, 32'h0);
    checkCsr("post-reset mepc", CSR_MEPC, 32'h0);
    checkCsr("post-reset mcause", CSR_MCAUSE, 32'h0);
    checkCsr("post-reset mtval", CSR_MTVAL, 32'h0);
    checkCsr("unmapped read", 12'h7C0, 32'h0);

    idleCycles(4);
    checkOutput("scoreboard drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
